// File: rtl/ddr5_rsp_pkg.sv
// Shared types and constants for the DDR5 command responder and its bench.
package ddr5_rsp_pkg;

  localparam int unsigned BG_W   = 3;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned ROW_W  = 16;
  localparam int unsigned COL_W  = 8;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT0 = 3'd1,
    CMD_ACT1 = 3'd2,
    CMD_RD   = 3'd3,
    CMD_WR   = 3'd4,
    CMD_PRE  = 3'd5
  } cmd_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ACT_SEQ   = 3'd1,
    ERR_BANK_BUSY = 3'd2,
    ERR_NOT_OPEN  = 3'd3,
    ERR_TRCD      = 3'd4,
    ERR_TRAS      = 3'd5,
    ERR_TRP       = 3'd6
  } err_t;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_ACT_PEND,
    BS_OPEN,
    BS_CLOSING
  } bank_state_t;

  typedef struct packed {
    logic [BG_W-1:0]   bg;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } rd_tag_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ddr5_rsp_delay_line.sv
// Fixed-latency shift pipeline with per-stage valid; one slot per cycle.
module ddr5_rsp_delay_line #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    dat_d[0] = in_valid ? in_data : '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/ddr5_cmd_responder.sv
// DDR5 device-side responder: per-bank state/timing check, error reporting, RD/WR completions.
// Optional DDR5_RSP_TRACE_EN adds a simulation-only command trace.
module ddr5_cmd_responder
  import ddr5_rsp_pkg::*;
#(
  parameter int unsigned NUM_BG   = 8,
  parameter int unsigned NUM_BANK = 4,
  parameter int unsigned T_RCD    = 39,
  parameter int unsigned T_RAS    = 76,
  parameter int unsigned T_RP     = 39,
  parameter int unsigned T_CL     = 40,
  parameter int unsigned T_CWL    = 38
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  input  logic [2:0]                   cmd,
  input  logic [BG_W-1:0]              cmd_bg,
  input  logic [BANK_W-1:0]            cmd_bank,
  input  logic [ROW_W-1:0]             cmd_row,
  input  logic [COL_W-1:0]             cmd_col,
  output logic                         err_valid,
  output logic [2:0]                   err_code,
  output logic [15:0]                  err_count,
  output logic                         rd_valid,
  output logic [BG_W-1:0]              rd_bg,
  output logic [BANK_W-1:0]            rd_bank,
  output logic [ROW_W-1:0]             rd_row,
  output logic [COL_W-1:0]             rd_col,
  output logic                         wr_ack,
  output logic [NUM_BG*NUM_BANK-1:0]   open_banks
);

  localparam int unsigned NB    = NUM_BG * NUM_BANK;
  localparam int unsigned IDX_W = BG_W + BANK_W;
  localparam logic [7:0] RCD_C = 8'(T_RCD);
  localparam logic [7:0] RAS_C = 8'(T_RAS);
  localparam logic [7:0] RP_C  = 8'(T_RP);

  bank_state_t          state_q   [NB];
  bank_state_t          state_d   [NB];
  logic [7:0]           cnt_act_q [NB];
  logic [7:0]           cnt_act_d [NB];
  logic [7:0]           cnt_pre_q [NB];
  logic [7:0]           cnt_pre_d [NB];
  logic [ROW_W-1:0]     row_q     [NB];
  logic [ROW_W-1:0]     row_d     [NB];
  logic                 pend_q, pend_d;
  logic [IDX_W-1:0]     pend_idx_q, pend_idx_d;
  logic                 err_valid_q, err_valid_d;
  err_t                 err_code_q, err_d, op_err;
  logic [15:0]          err_count_q, err_count_d;

  logic [IDX_W-1:0]     idx;
  logic                 act1_match;
  cmd_t                 op;
  logic                 rd_push, wr_push;
  rd_tag_t              rd_tag_in, rd_tag_out;
  logic                 rd_v_out, wr_v_out;
  logic [0:0]           wr_d_out;

  assign idx        = {cmd_bg, cmd_bank};
  assign act1_match = pend_q && cmd_valid && (cmd_t'(cmd) == CMD_ACT1) && (idx == pend_idx_q);

  always_comb begin
    for (int unsigned i = 0; i < NB; i++) begin
      state_d[i]   = state_q[i];
      cnt_act_d[i] = sat_inc8(cnt_act_q[i]);
      cnt_pre_d[i] = sat_inc8(cnt_pre_q[i]);
      row_d[i]     = row_q[i];
      // A closing bank whose tRP has elapsed is IDLE for this cycle's command too
      if (state_q[i] == BS_CLOSING && cnt_pre_q[i] >= RP_C) state_d[i] = BS_IDLE;
    end
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    err_d      = ERR_NONE;
    op_err     = ERR_NONE;
    rd_push    = 1'b0;
    wr_push    = 1'b0;
    rd_tag_in  = '{bg: cmd_bg, bank: cmd_bank, row: row_q[idx], col: cmd_col};
    op         = cmd_valid ? cmd_t'(cmd) : CMD_NOP;

    // Pending activate is resolved first; a broken pair frees the bank so the
    // offending command is then judged against IDLE.
    if (pend_q) begin
      if (act1_match) begin
        state_d[pend_idx_q]   = BS_OPEN;
        cnt_act_d[pend_idx_q] = 8'd1;
        op                    = CMD_NOP;
      end else begin
        state_d[pend_idx_q] = BS_IDLE;
        err_d               = ERR_ACT_SEQ;
      end
    end

    case (op)
      CMD_ACT0: begin
        case (state_d[idx])
          BS_IDLE: begin
            state_d[idx] = BS_ACT_PEND;
            row_d[idx]   = cmd_row;
            pend_d       = 1'b1;
            pend_idx_d   = idx;
          end
          BS_CLOSING: op_err = ERR_TRP;
          default:    op_err = ERR_BANK_BUSY;
        endcase
      end
      CMD_ACT1: op_err = ERR_ACT_SEQ;
      CMD_RD, CMD_WR: begin
        if (state_d[idx] != BS_OPEN)     op_err = ERR_NOT_OPEN;
        else if (cnt_act_q[idx] < RCD_C) op_err = ERR_TRCD;
        else if (op == CMD_RD)           rd_push = 1'b1;
        else                             wr_push = 1'b1;
      end
      CMD_PRE: begin
        if (state_d[idx] == BS_OPEN) begin
          if (cnt_act_q[idx] < RAS_C) op_err = ERR_TRAS;
          else begin
            state_d[idx]   = BS_CLOSING;
            cnt_pre_d[idx] = 8'd1;
          end
        end
      end
      default: ;
    endcase

    if (err_d == ERR_NONE) err_d = op_err;
    err_valid_d = (err_d != ERR_NONE);
    err_count_d = (err_valid_d && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NB; i++) begin
        state_q[i]   <= BS_IDLE;
        cnt_act_q[i] <= '0;
        cnt_pre_q[i] <= '0;
        row_q[i]     <= '0;
      end
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_act_q   <= cnt_act_d;
      cnt_pre_q   <= cnt_pre_d;
      row_q       <= row_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    open_banks = '0;
    for (int unsigned i = 0; i < NB; i++) open_banks[i] = (state_q[i] == BS_OPEN);
  end

  ddr5_rsp_delay_line #(.DEPTH(T_CL), .WIDTH($bits(rd_tag_t))) u_rd_line (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_push),
    .in_data   (rd_tag_in),
    .out_valid (rd_v_out),
    .out_data  (rd_tag_out)
  );

  ddr5_rsp_delay_line #(.DEPTH(T_CWL), .WIDTH(1)) u_wr_line (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (wr_push),
    .in_data   (1'b1),
    .out_valid (wr_v_out),
    .out_data  (wr_d_out)
  );

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;
  assign rd_valid  = rd_v_out;
  assign rd_bg     = rd_tag_out.bg;
  assign rd_bank   = rd_tag_out.bank;
  assign rd_row    = rd_tag_out.row;
  assign rd_col    = rd_tag_out.col;
  assign wr_ack    = wr_v_out & wr_d_out[0];

`ifdef DDR5_RSP_TRACE_EN
  int unsigned trace_cyc;

  initial trace_cyc = 0;

  always @(posedge clock) begin
    if (!reset) begin
      if (cmd_valid && cmd_t'(cmd) != CMD_NOP && (act1_match || op_err == ERR_NONE)) begin
        case (cmd_t'(cmd))
          CMD_ACT0: $display("%0d 0 %s %0d %0d %h", trace_cyc, cmd_t'(cmd).name(), cmd_bg, cmd_bank, cmd_row);
          CMD_ACT1: $display("%0d 0 %s %0d %0d %h", trace_cyc, cmd_t'(cmd).name(), cmd_bg, cmd_bank, row_q[idx]);
          CMD_RD, CMD_WR: $display("%0d 0 %s %0d %0d %h", trace_cyc, cmd_t'(cmd).name(), cmd_bg, cmd_bank, cmd_col);
          default: $display("%0d 0 %s %0d %0d", trace_cyc, cmd_t'(cmd).name(), cmd_bg, cmd_bank);
        endcase
      end
      if (err_valid_d) $display("ERR %0d", err_d);
    end
    trace_cyc = trace_cyc + 1;
  end
`endif

endmodule

// File: tb/tb_ddr5_cmd_responder.sv
// Table-driven bench for ddr5_cmd_responder with a completion/error scoreboard.
module tb_ddr5_cmd_responder;
  import ddr5_rsp_pkg::*;

  localparam int unsigned TB_CL  = 40;
  localparam int unsigned TB_CWL = 38;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [2:0]  cmd_bg = '0;
  logic [1:0]  cmd_bank = '0;
  logic [15:0] cmd_row = '0;
  logic [7:0]  cmd_col = '0;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [15:0] err_count;
  logic        rd_valid;
  logic [2:0]  rd_bg;
  logic [1:0]  rd_bank;
  logic [15:0] rd_row;
  logic [7:0]  rd_col;
  logic        wr_ack;
  logic [31:0] open_banks;

  ddr5_cmd_responder #(
    .NUM_BG(8), .NUM_BANK(4), .T_RCD(39), .T_RAS(76), .T_RP(39), .T_CL(TB_CL), .T_CWL(TB_CWL)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bg(cmd_bg),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .err_valid(err_valid),
    .err_code(err_code), .err_count(err_count), .rd_valid(rd_valid), .rd_bg(rd_bg),
    .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col), .wr_ack(wr_ack), .open_banks(open_banks)
  );

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // cyc is bumped before the rising edge so edge-waiters see the new cycle number
  initial forever begin
    #5 cyc = cyc + 1; clock = 1'b1;
    #5 clock = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required<done>", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
    end
  endtask

  typedef struct { int unsigned cyc; logic [2:0] code; } err_exp_t;
  typedef struct { int unsigned cyc; logic [28:0] tag; } rd_exp_t;

  err_exp_t    err_q[$];
  rd_exp_t     rd_q[$];
  int unsigned wr_q[$];
  int unsigned rd_pulses = 0;
  int unsigned exp_errs = 0;

  always @(negedge clock) begin : monitor
    err_exp_t e;
    rd_exp_t  r;
    int unsigned w;
    if (reset) begin
      check("reset_outputs", {err_valid, err_code, err_count, rd_valid, rd_bg, rd_bank, rd_row, rd_col, wr_ack}, '0);
      check("reset_open_banks", open_banks, '0);
    end else begin
      if (err_valid) begin
        if (err_q.size() == 0) check("err_valid_unexpected", err_valid, 1'b0);
        else begin
          e = err_q.pop_front();
          check("err_cycle", cyc, e.cyc);
          check("err_code", err_code, e.code);
        end
      end else if (err_q.size() > 0 && err_q[0].cyc <= cyc) begin
        e = err_q.pop_front();
        check("err_valid_missing", err_valid, 1'b1);
      end
      if (rd_valid) begin
        rd_pulses++;
        if (rd_q.size() == 0) check("rd_valid_unexpected", rd_valid, 1'b0);
        else begin
          r = rd_q.pop_front();
          check("rd_cycle", cyc, r.cyc);
          check("rd_tag", {rd_bg, rd_bank, rd_row, rd_col}, r.tag);
        end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        r = rd_q.pop_front();
        check("rd_valid_missing", rd_valid, 1'b1);
      end
      if (wr_ack) begin
        if (wr_q.size() == 0) check("wr_ack_unexpected", wr_ack, 1'b0);
        else begin
          w = wr_q.pop_front();
          check("wr_cycle", cyc, w);
        end
      end else if (wr_q.size() > 0 && wr_q[0] <= cyc) begin
        w = wr_q.pop_front();
        check("wr_ack_missing", wr_ack, 1'b1);
      end
    end
  end

  typedef struct {
    int          sc;
    int unsigned cyc;
    cmd_t        cmd;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [7:0]  col;
    logic [2:0]  exp_err;
    logic [15:0] exp_row;
    logic [31:0] exp_open;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int sc, int unsigned c, cmd_t cm, logic [2:0] bg, logic [1:0] bk,
                              logic [15:0] row, logic [7:0] col, logic [2:0] ee,
                              logic [15:0] er, logic [31:0] eo);
    vecs.push_back('{sc, c, cm, bg, bk, row, col, ee, er, eo});
  endfunction

  task automatic flush_sb();
    err_q.delete();
    rd_q.delete();
    wr_q.delete();
    exp_errs = 0;
  endtask

  task automatic do_reset(output int unsigned base);
    @(posedge clock);
    #1 reset = 1'b1;
    flush_sb();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    base = cyc;
  endtask

  task automatic apply(input vec_t v, input int unsigned base);
    int unsigned t;
    t = base + v.cyc;
    while (cyc < t) @(posedge clock);
    #1;
    cmd_valid = 1'b1;
    cmd       = v.cmd;
    cmd_bg    = v.bg;
    cmd_bank  = v.bank;
    cmd_row   = v.row;
    cmd_col   = v.col;
    if (v.exp_err != 3'd0) begin
      err_q.push_back('{t + 1, v.exp_err});
      exp_errs++;
    end else if (v.cmd == CMD_RD) begin
      rd_q.push_back('{t + TB_CL, {v.bg, v.bank, v.exp_row, v.col}});
    end else if (v.cmd == CMD_WR) begin
      wr_q.push_back(t + TB_CWL);
    end
    @(negedge clock);
    check("open_banks", open_banks, v.exp_open);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    cmd = CMD_NOP;
  endtask

  task automatic run_sc(input int sc, output int unsigned base, output int unsigned last);
    do_reset(base);
    last = 0;
    foreach (vecs[i]) begin
      if (vecs[i].sc == sc) begin
        apply(vecs[i], base);
        last = vecs[i].cyc;
      end
    end
  endtask

  task automatic finish_sc(input int unsigned base, input int unsigned last);
    while (cyc < base + last + TB_CL + 5) @(posedge clock);
    @(negedge clock);
    check("scoreboard_drained", err_q.size() + rd_q.size() + wr_q.size(), 0);
    check("err_count", err_count, exp_errs);
  endtask

  initial begin : main
    int unsigned base, last, p0;
    int sc_list[5] = '{1, 2, 3, 4, 6};

    // sc cyc cmd bg bank row col exp_err exp_row exp_open
    add(1, 10, CMD_ACT0, 2, 1, 16'h1234, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(1, 11, CMD_ACT1, 2, 1, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(1, 12, CMD_NOP,  0, 0, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h200);
    add(1, 50, CMD_RD,   2, 1, 16'h0000, 8'h5A, 3'd0, 16'h1234, 32'h200);

    add(2, 10, CMD_ACT0, 2, 1, 16'h1234, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(2, 11, CMD_ACT1, 2, 1, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(2, 49, CMD_RD,   2, 1, 16'h0000, 8'h5A, 3'd4, 16'h0000, 32'h200);

    add(3, 10, CMD_ACT0, 0, 0, 16'h00AA, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(3, 11, CMD_NOP,  0, 0, 16'h0000, 8'h00, 3'd1, 16'h0000, 32'h0);
    add(3, 20, CMD_RD,   0, 0, 16'h0000, 8'h01, 3'd3, 16'h0000, 32'h0);
    add(3, 30, CMD_ACT0, 0, 0, 16'h0007, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(3, 31, CMD_ACT0, 0, 0, 16'h0008, 8'h00, 3'd1, 16'h0000, 32'h0);
    add(3, 32, CMD_ACT1, 0, 0, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(3, 33, CMD_NOP,  0, 0, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h1);
    add(3, 71, CMD_RD,   0, 0, 16'h0000, 8'h11, 3'd0, 16'h0008, 32'h1);

    add(4, 10,  CMD_ACT0, 3, 2, 16'hBEEF, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(4, 11,  CMD_ACT1, 3, 2, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(4, 86,  CMD_PRE,  3, 2, 16'h0000, 8'h00, 3'd5, 16'h0000, 32'h4000);
    add(4, 87,  CMD_PRE,  3, 2, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h4000);
    add(4, 88,  CMD_NOP,  0, 0, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(4, 100, CMD_RD,   3, 2, 16'h0000, 8'h22, 3'd3, 16'h0000, 32'h0);
    add(4, 110, CMD_PRE,  3, 2, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(4, 125, CMD_ACT0, 3, 2, 16'hCAFE, 8'h00, 3'd6, 16'h0000, 32'h0);
    add(4, 126, CMD_ACT0, 3, 2, 16'hCAFE, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(4, 127, CMD_ACT1, 3, 2, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(4, 128, CMD_NOP,  0, 0, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h4000);
    add(4, 166, CMD_RD,   3, 2, 16'h0000, 8'h33, 3'd0, 16'hCAFE, 32'h4000);
    add(4, 170, CMD_WR,   3, 2, 16'h0000, 8'h44, 3'd0, 16'h0000, 32'h4000);
    add(4, 180, CMD_ACT0, 3, 2, 16'h0001, 8'h00, 3'd2, 16'h0000, 32'h4000);
    add(4, 190, CMD_ACT1, 3, 2, 16'h0000, 8'h00, 3'd1, 16'h0000, 32'h4000);
    add(4, 195, CMD_PRE,  7, 3, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h4000);
    add(4, 200, CMD_RD,   7, 3, 16'h0000, 8'h01, 3'd3, 16'h0000, 32'h4000);
    add(4, 210, CMD_RD,   3, 2, 16'h0000, 8'h55, 3'd0, 16'hCAFE, 32'h4000);

    add(5, 10, CMD_ACT0, 5, 0, 16'h5555, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(5, 11, CMD_ACT1, 5, 0, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(5, 50, CMD_RD,   5, 0, 16'h0000, 8'h01, 3'd0, 16'h5555, 32'h100000);

    add(6, 50,  CMD_ACT0, 1, 0, 16'h1010, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(6, 51,  CMD_ACT1, 1, 0, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h0);
    add(6, 52,  CMD_ACT0, 4, 3, 16'h4343, 8'h00, 3'd0, 16'h0000, 32'h10);
    add(6, 53,  CMD_ACT1, 4, 3, 16'h0000, 8'h00, 3'd0, 16'h0000, 32'h10);
    add(6, 100, CMD_RD,   1, 0, 16'h0000, 8'hA1, 3'd0, 16'h1010, 32'h80010);
    add(6, 101, CMD_RD,   4, 3, 16'h0000, 8'hB2, 3'd0, 16'h4343, 32'h80010);
    add(6, 102, CMD_WR,   1, 0, 16'h0000, 8'hC3, 3'd0, 16'h0000, 32'h80010);
    add(6, 103, CMD_WR,   4, 3, 16'h0000, 8'hD4, 3'd0, 16'h0000, 32'h80010);

    foreach (sc_list[k]) begin
      run_sc(sc_list[k], base, last);
      finish_sc(base, last);
    end

    // Reset with a read in flight: the completion is dropped with everything else
    run_sc(5, base, last);
    while (cyc < base + 60) @(posedge clock);
    #1 reset = 1'b1;
    flush_sb();
    p0 = rd_pulses;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    while (cyc < base + 100) @(posedge clock);
    @(negedge clock);
    check("rd_pulses_after_reset", rd_pulses - p0, 0);
    check("open_banks_after_reset", open_banks, 32'h0);
    check("err_count_after_reset", err_count, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
